// File: rtl/sub2_pkg.sv
// sub2_pkg: shared types for the serial 2-bit-digit subtractor.
// Holds the FSM state enum and the digit width.
package sub2_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub2_cell.sv
// sub2_cell: combinational 2-bit digit subtractor.
// Ports: a, b (digits), bin (borrow in) -> d (digit diff), bout.
module sub2_cell
  import sub2_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] diff;

  // The extra MSB goes to 1 exactly when a - b - bin underflows.
  assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
  assign d    = diff[DIGIT_W-1:0];
  assign bout = diff[DIGIT_W];

endmodule

// File: rtl/sub2_serial.sv
// sub2_serial: serial subtractor, one 2-bit digit per cycle, LSB first.
// Ports: CLK, Resetn (sync, active-high), A/B/in_valid/in_ready, D/C/out_valid/out_ready.
module sub2_serial
  import sub2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             C,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic             c_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [IDX_W:0]       base;
  logic [DIGIT_W-1:0]   dig_a;
  logic [DIGIT_W-1:0]   dig_b;
  logic [DIGIT_W-1:0]   dig_d;
  logic                 dig_bout;

  // Bit offset of the current digit: idx * DIGIT_W with DIGIT_W = 2.
  assign base  = {idx, 1'b0};
  assign dig_a = a_q[base +: DIGIT_W];
  assign dig_b = b_q[base +: DIGIT_W];

  sub2_cell u_cell (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (borrow),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_ff @(posedge CLK) begin
    if (Resetn) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      idx         <= '0;
      borrow      <= 1'b0;
      c_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            borrow     <= 1'b0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          d_q[base +: DIGIT_W] <= dig_d;
          borrow <= dig_bout;
          if (idx == LAST) begin
            c_q         <= dig_bout;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Handoff always lands in IDLE; no same-cycle re-accept.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign C         = c_q;

endmodule

// File: tb/tb_sub2_serial.sv
// tb_sub2_serial: scoreboard bench for sub2_serial (WIDTH=8).
// Driver pushes expected results; a negedge monitor pops on each handoff.
module tb_sub2_serial;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             Resetn = 1'b1;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] D;
  logic             C;
  logic             out_valid;
  logic             out_ready = 1'b1;

  always #5 CLK = ~CLK;

  sub2_serial #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .Resetn    (Resetn),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [7:0] d;
    logic       c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  bit   rnd_done = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Reference: plain integer subtraction, borrow when A < B unsigned.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int   diff;
    diff = int'(a) - int'(b);
    r.c  = (diff < 0);
    r.d  = 8'((diff + 256) % 256);
    return r;
  endfunction

  always @(negedge CLK) begin
    if (!Resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(D), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("D", 32'(D), 32'(mon_e.d));
        check("C", 32'(C), 32'(mon_e.c));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input bit hold);
    int n;
    A = a;
    B = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(n), 32'd0);
    end else begin
      sb.push_back(model(a, b));
    end
    @(posedge CLK); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int k;
    logic [7:0] ra, rb;

    // Reset for 3 cycles.
    Resetn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    Resetn = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_C", 32'(C), 32'd0);

    // Basic case plus latency from accept edge to out_valid.
    send(8'h5A, 8'h3C, 1'b0);
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (!out_valid && k < 20);
    check("latency", 32'(k), 32'd4);
    wait_idle();

    send(8'h00, 8'h01, 1'b0);
    wait_idle();
    send(8'h80, 8'h80, 1'b0);
    wait_idle();
    send(8'hFF, 8'h00, 1'b0);
    wait_idle();

    // Backpressure: result held, no accept while DONE.
    out_ready = 1'b0;
    send(8'h5A, 8'h3C, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge CLK); #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_D", 32'(D), 32'h1E);
      check("bp_C", 32'(C), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      A = 8'h11;
      B = 8'h00;
      in_valid = (i == 1 || i == 2);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (8) @(posedge CLK);
    #1;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    send(8'h5A, 8'h3C, 1'b0);
    @(posedge CLK); #1;
    Resetn = 1'b1;
    sb.delete();
    @(posedge CLK); #1;
    Resetn = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_D", 32'(D), 32'd0);
    check("abort_C", 32'(C), 32'd0);
    send(8'h03, 8'h05, 1'b0);
    wait_idle();

    // Back-to-back with in_valid held high; operands change during RUN.
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, i != 2);
    end
    wait_idle();

    // Random operands with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          send(ra, rb, $urandom_range(0, 1) == 1);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(posedge CLK);
          #0;
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             passed, total);
    $fatal(1);
  end

endmodule
